hanoi_solver: RTL and testbench

//  Sequencer for the hanoi ring-state register (M=3 pegs). On start it checks that all N rings are on peg 0.
//  It then issues the 2^N-1 optimal moves as (ind, loc) pairs, one move per two cycles, and checks each move's legality.

---
 rtl/hanoi_pkg.sv | 37 +++
 rtl/hanoi_move_gen.sv | 71 +++++++
 rtl/hanoi_solver.sv | 172 +++++++++++++++++
 tb/tb_hanoi_solver.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hanoi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hanoi_pkg
// Description : Shared peg constants, solver state and error encodings, and
//               the optimal-move-count helper for the hanoi sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hanoi_pkg;

    // Peg count and width of one ring-location field
    localparam int M  = 3;
    localparam int LW = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK_INIT = 3'd1,
        ST_CALC       = 3'd2,
        ST_APPLY      = 3'd3,
        ST_FINAL      = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_BAD_INIT  = 2'd1,
        ERR_ILLEGAL   = 2'd2,
        ERR_BAD_FINAL = 2'd3
    } err_t;

    // Number of moves in the optimal solution for n rings
    function automatic int N_MOVES(input int n);
        return (1 << n) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hanoi_move_gen.sv
`default_nettype none
// ============================================================================
// Module      : hanoi_move_gen
// Description : Combinational next-move generator. Move k = move_cnt+1 moves
//               ring ctz(k); the smallest ring steps the same direction on
//               every move, larger rings alternate by parity of (N - d).
//               Also checks the move against the current ring image.
// Revision    : 1.0 - initial release
// ============================================================================
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N*LW-1:0] rings,
    input  logic [N-1:0]    move_cnt,
    output logic [IW-1:0]   d,
    output logic [LW-1:0]   dst,
    output logic            legal
);

    localparam logic [N-1:0]  c_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic          c_N_ODD = ((N % 2) == 1);
    localparam logic [LW:0]   c_M     = (LW+1)'(M);
    localparam logic [LW-1:0] c_NOPEG = {LW{1'b1}};

    logic [N-1:0]  w_k;
    logic [LW-1:0] w_src;
    logic [LW:0]   w_step;
    logic [LW:0]   w_sum;
    logic          w_conflict;

    assign w_k = move_cnt + c_ONE;

    // Ring to move is the lowest set bit of k; fetch its current peg
    always_comb begin : p_select
        d     = '0;
        w_src = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_k[i]) begin
                d     = IW'(i);
                w_src = rings[i*LW +: LW];
            end
        end
    end

    // Target peg: step by 2 when (N - d) is odd, else by 1, modulo 3
    always_comb begin : p_dst
        w_step = (c_N_ODD ^ d[0]) ? (LW+1)'(2) : (LW+1)'(1);
        w_sum  = {1'b0, w_src} + w_step;
        if (w_sum >= c_M) begin
            w_sum = w_sum - c_M;
        end
        dst = w_sum[LW-1:0];
    end

    // A smaller ring sitting on either the source or target peg blocks the move
    always_comb begin : p_legal
        w_conflict = 1'b0;
        for (int j = 0; j < N; j++) begin
            if ((IW'(j) < d) &&
                ((rings[j*LW +: LW] == w_src) || (rings[j*LW +: LW] == dst))) begin
                w_conflict = 1'b1;
            end
        end
        legal = (w_src != c_NOPEG) && !w_conflict;
    end

endmodule
`default_nettype wire

// File: rtl/hanoi_solver.sv
`default_nettype none
// ============================================================================
// Module      : hanoi_solver
// Description : Sequencer driving the hanoi ring-state register. Verifies the
//               starting image, issues the 2^N-1 optimal moves one per two
//               cycles with a legality check on each, then verifies that all
//               rings finished on peg 2.
// Revision    : 1.0 - initial release
// ============================================================================
module hanoi_solver
    import hanoi_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic [N*LW-1:0]      rings_i,
    output logic [$clog2(N)-1:0] ind,
    output logic [LW-1:0]        loc,
    output logic                 move_vld,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [N-1:0]         move_cnt
);

    localparam int            IW          = $clog2(N);
    localparam int            c_N_MOVES   = N_MOVES(N);
    localparam int            c_PENULT_I  = c_N_MOVES - 1;
    localparam logic [N-1:0]  c_LAST      = c_N_MOVES[N-1:0];
    localparam logic [N-1:0]  c_PENULT    = c_PENULT_I[N-1:0];
    localparam logic [N-1:0]  c_ONE       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N*LW-1:0] c_ALL_TWO = {N{2'd2}};

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_ind;
    logic [LW-1:0] r_loc;
    err_t          r_err;
    logic [N-1:0]  r_move_cnt;

    logic [IW-1:0] w_d;
    logic [LW-1:0] w_dst;
    logic          w_legal;
    logic          w_init_ok;
    logic          w_final_ok;
    logic          w_at_last;
    logic          w_apply_last;

    hanoi_move_gen #(
        .N  (N),
        .IW (IW)
    ) u_move_gen (
        .rings    (rings_i),
        .move_cnt (r_move_cnt),
        .d        (w_d),
        .dst      (w_dst),
        .legal    (w_legal)
    );

    assign w_init_ok    = (rings_i == '0);
    assign w_final_ok   = (rings_i == c_ALL_TWO);
    assign w_at_last    = (r_move_cnt == c_LAST);
    // The move applied this cycle is the last one, so the hanoi image is
    // complete after this edge and FINAL can check it directly
    assign w_apply_last = (r_move_cnt == c_PENULT);

    // State register
    always_ff @(posedge clk) begin : p_state_reg
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin : p_next_state
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_next_state = ST_CHECK_INIT;
                end
            end
            ST_CHECK_INIT: begin
                w_next_state = w_init_ok ? ST_CALC : ST_ERROR;
            end
            ST_CALC: begin
                if (!pause) begin
                    if (w_at_last) begin
                        w_next_state = ST_FINAL;
                    end else if (w_legal) begin
                        w_next_state = ST_APPLY;
                    end else begin
                        w_next_state = ST_ERROR;
                    end
                end
            end
            ST_APPLY: begin
                w_next_state = w_apply_last ? ST_FINAL : ST_CALC;
            end
            ST_FINAL: begin
                w_next_state = w_final_ok ? ST_DONE : ST_ERROR;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State-decoded status outputs
    always_comb begin : p_outputs
        move_vld = (r_state == ST_APPLY);
        busy     = (r_state == ST_CHECK_INIT) || (r_state == ST_CALC) ||
                   (r_state == ST_APPLY);
        done     = (r_state == ST_DONE);
    end

    // Move registers, sticky error code and applied-move counter
    always_ff @(posedge clk) begin : p_datapath
        if (rst) begin
            r_ind      <= '0;
            r_loc      <= '0;
            r_err      <= ERR_OK;
            r_move_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_err      <= ERR_OK;
                        r_move_cnt <= '0;
                    end
                end
                ST_CHECK_INIT: begin
                    if (!w_init_ok) begin
                        r_err <= ERR_BAD_INIT;
                    end
                end
                ST_CALC: begin
                    if (!pause && !w_at_last) begin
                        if (w_legal) begin
                            r_ind <= w_d;
                            r_loc <= w_dst;
                        end else begin
                            r_err <= ERR_ILLEGAL;
                        end
                    end
                end
                ST_APPLY: begin
                    r_move_cnt <= r_move_cnt + c_ONE;
                end
                ST_FINAL: begin
                    if (!w_final_ok) begin
                        r_err <= ERR_BAD_FINAL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ind      = r_ind;
    assign loc      = r_loc;
    assign err      = r_err;
    assign move_cnt = r_move_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hanoi_solver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hanoi_solver
// Description : Scoreboard bench for hanoi_solver (N=3 and N=4) with a model
//               of the hanoi ring register closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hanoi_solver;

    logic clk;
    logic rst;
    logic hrst;

    logic       start3, pause3;
    logic [5:0] h3, rings3, ovr3_val;
    logic       ovr3_en;
    logic [1:0] ind3, loc3, err3;
    logic       mv3, busy3, done3;
    logic [2:0] cnt3;

    logic       start4, pause4;
    logic [7:0] h4;
    logic [1:0] ind4, loc4, err4;
    logic       mv4, busy4, done4;
    logic [3:0] cnt4;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp3[$];
    logic [3:0] exp4[$];

    // Hand-derived optimal sequences, packed {ind, loc}
    logic [3:0] seq3 [7]  = '{4'b00_10, 4'b01_01, 4'b00_01, 4'b10_10,
                              4'b00_00, 4'b01_10, 4'b00_10};
    logic [3:0] seq4 [15] = '{4'b00_01, 4'b01_10, 4'b00_10, 4'b10_01,
                              4'b00_00, 4'b01_01, 4'b00_01, 4'b11_10,
                              4'b00_10, 4'b01_00, 4'b00_00, 4'b10_10,
                              4'b00_01, 4'b01_10, 4'b00_10};

    assign rings3 = ovr3_en ? ovr3_val : h3;

    hanoi_solver #(.N(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .pause(pause3), .rings_i(rings3),
        .ind(ind3), .loc(loc3), .move_vld(mv3), .busy(busy3), .done(done3),
        .err(err3), .move_cnt(cnt3)
    );

    hanoi_solver #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .pause(pause4), .rings_i(h4),
        .ind(ind4), .loc(loc4), .move_vld(mv4), .busy(busy4), .done(done4),
        .err(err4), .move_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hanoi model: writes ring ind with loc on every clock
    always_ff @(posedge clk) begin
        if (hrst) begin
            h3 <= '0;
            h4 <= '0;
        end else begin
            for (int i = 0; i < 3; i++) if (ind3 == 2'(i)) h3[i*2 +: 2] <= loc3;
            for (int i = 0; i < 4; i++) if (ind4 == 2'(i)) h4[i*2 +: 2] <= loc4;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every move_vld pops one expected move
    always @(negedge clk) begin
        logic [3:0] e;
        if (mv3) begin
            if (exp3.size() == 0) begin
                checks++; errors++;
                $display("FAIL move3_unexpected: actual ind=%0d loc=%0d required no move", ind3, loc3);
            end else begin
                e = exp3.pop_front();
                check("move3", {ind3, loc3}, e);
            end
        end
        if (mv4) begin
            if (exp4.size() == 0) begin
                checks++; errors++;
                $display("FAIL move4_unexpected: actual ind=%0d loc=%0d required no move", ind4, loc4);
            end else begin
                e = exp4.pop_front();
                check("move4", {ind4, loc4}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic full_reset();
        rst = 1'b1; hrst = 1'b1;
        tick(); tick();
        rst = 1'b0; hrst = 1'b0;
    endtask

    task automatic pulse_start3();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
    endtask

    // Run DUT3 from start until done/err; cycle 1 is the cycle after the start edge
    task automatic run3(input int p_on, input int p_off,
                        output int done_cyc, output int first_mv, output int win_mv);
        int cyc;
        done_cyc = -1; first_mv = -1; win_mv = 0;
        pulse_start3();
        cyc = 1;
        while (cyc < 200) begin
            pause3 = (cyc >= p_on) && (cyc < p_off);
            if (mv3 && first_mv < 0) first_mv = cyc;
            if (mv3 && cyc >= p_on && cyc <= p_off) win_mv++;
            if (done3 || err3 != 2'd0) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        pause3 = 1'b0;
    endtask

    task automatic wait_cnt3(input int target, input int cyc0, output int at_cyc);
        int cyc;
        at_cyc = -1;
        cyc = cyc0;
        while (cyc < 200) begin
            if (int'(cnt3) == target) begin
                at_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int dc, fm, wm, at, cyc;
        start3 = 0; pause3 = 0; ovr3_en = 0; ovr3_val = '0;
        start4 = 0; pause4 = 0;
        rst = 1'b1; hrst = 1'b1;
        tick(); tick();

        // Reset values
        check("rst_ind", ind3, 0);
        check("rst_loc", loc3, 0);
        check("rst_move_vld", mv3, 0);
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_err", err3, 0);
        check("rst_move_cnt", cnt3, 0);
        check("rst_done4", done4, 0);
        rst = 1'b0; hrst = 1'b0;

        // Test 1: full N=3 solve
        foreach (seq3[i]) exp3.push_back(seq3[i]);
        run3(0, 0, dc, fm, wm);
        check("t1_first_move_cycle", fm, 3);
        check("t1_done_cycle", dc, 17);
        check("t1_done", done3, 1);
        check("t1_busy", busy3, 0);
        check("t1_err", err3, 0);
        check("t1_move_cnt", cnt3, 7);
        check("t1_rings", rings3, 6'b10_10_10);
        check("t1_moves_left", exp3.size(), 0);

        // Start from DONE without resetting hanoi
        run3(0, 0, dc, fm, wm);
        check("t1b_err_cycle", dc, 2);
        check("t1b_err", err3, 1);
        check("t1b_move_cnt", cnt3, 0);
        check("t1b_no_move", fm, -1);

        // Test 2: N=4
        full_reset();
        foreach (seq4[i]) exp4.push_back(seq4[i]);
        start4 = 1'b1; tick(); start4 = 1'b0;
        cyc = 1; dc = -1;
        while (cyc < 200) begin
            if (done4 || err4 != 2'd0) begin
                dc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        check("t2_done_cycle", dc, 33);
        check("t2_done", done4, 1);
        check("t2_err", err4, 0);
        check("t2_move_cnt", cnt4, 15);
        check("t2_rings", h4, 8'hAA);
        check("t2_moves_left", exp4.size(), 0);

        // Test 3: bad initial image
        full_reset();
        ovr3_val = 6'b00_01_00; ovr3_en = 1'b1;
        run3(0, 0, dc, fm, wm);
        check("t3_err_cycle", dc, 2);
        check("t3_err", err3, 1);
        check("t3_no_move", fm, -1);
        check("t3_busy", busy3, 0);
        ovr3_en = 1'b0;

        // Test 4: ring 0 corrupted to invalid peg before move 3
        full_reset();
        exp3.push_back(seq3[0]); exp3.push_back(seq3[1]);
        pulse_start3();
        wait_cnt3(2, 1, at);
        check("t4_cnt2_cycle", at, 6);
        ovr3_val = {h3[5:2], 2'b11}; ovr3_en = 1'b1;
        tick();
        check("t4_err", err3, 2);
        check("t4_move_cnt", cnt3, 2);
        check("t4_ind_hold", ind3, 1);
        check("t4_loc_hold", loc3, 1);
        check("t4_busy", busy3, 0);
        ovr3_en = 1'b0;

        // Test 4b: smaller ring sits on the target peg of move 4
        full_reset();
        for (int i = 0; i < 3; i++) exp3.push_back(seq3[i]);
        pulse_start3();
        wait_cnt3(3, 1, at);
        check("t4b_cnt3_cycle", at, 8);
        ovr3_val = {h3[5:2], 2'b10}; ovr3_en = 1'b1;
        tick();
        check("t4b_err", err3, 2);
        check("t4b_move_cnt", cnt3, 3);
        check("t4b_ind_hold", ind3, 0);
        check("t4b_loc_hold", loc3, 1);
        ovr3_en = 1'b0;

        // Test 5: pause during cycles 4-9
        full_reset();
        foreach (seq3[i]) exp3.push_back(seq3[i]);
        run3(4, 10, dc, fm, wm);
        check("t5_first_move_cycle", fm, 3);
        check("t5_moves_in_pause", wm, 0);
        check("t5_done_cycle", dc, 23);
        check("t5_err", err3, 0);
        check("t5_move_cnt", cnt3, 7);
        check("t5_moves_left", exp3.size(), 0);

        // Test 6: start while busy ignored, rst after move 4, then rerun
        full_reset();
        foreach (seq3[i]) exp3.push_back(seq3[i]);
        pulse_start3();
        tick(); tick();
        start3 = 1'b1; tick(); start3 = 1'b0;
        check("t6_busy", busy3, 1);
        wait_cnt3(4, 4, at);
        check("t6_cnt4_cycle", at, 10);
        rst = 1'b1; hrst = 1'b1;
        exp3.delete();
        tick();
        check("t6_rst_ind", ind3, 0);
        check("t6_rst_loc", loc3, 0);
        check("t6_rst_move_vld", mv3, 0);
        check("t6_rst_busy", busy3, 0);
        check("t6_rst_done", done3, 0);
        check("t6_rst_err", err3, 0);
        check("t6_rst_move_cnt", cnt3, 0);
        rst = 1'b0; hrst = 1'b0;
        foreach (seq3[i]) exp3.push_back(seq3[i]);
        run3(0, 0, dc, fm, wm);
        check("t6_done_cycle", dc, 17);
        check("t6_move_cnt", cnt3, 7);
        check("t6_rings", rings3, 6'b10_10_10);
        check("t6_moves_left", exp3.size(), 0);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
